// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are gated by MDU_MADD_EN.
// Imported by mdu and mdu_arith.
package mdu_pkg;

    // Operation codes carried on mdop
    localparam logic [3:0] mdu_none  = 4'd0;
    localparam logic [3:0] mdu_mult  = 4'd1;
    localparam logic [3:0] mdu_multu = 4'd2;
    localparam logic [3:0] mdu_div   = 4'd3;
    localparam logic [3:0] mdu_divu  = 4'd4;
    localparam logic [3:0] mdu_mthi  = 4'd5;
    localparam logic [3:0] mdu_mtlo  = 4'd6;
    localparam logic [3:0] mdu_madd  = 4'd7;
    localparam logic [3:0] mdu_maddu = 4'd8;
    localparam logic [3:0] mdu_msub  = 4'd9;
    localparam logic [3:0] mdu_msubu = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    // Ops that run for MULT_CYCLES; accumulate ops only exist when enabled
    function automatic logic is_mult_op(input logic [3:0] op);
        logic r;
        r = (op == mdu_mult) || (op == mdu_multu);
`ifdef MDU_MADD_EN
        r = r || (op == mdu_madd) || (op == mdu_maddu) ||
                 (op == mdu_msub) || (op == mdu_msubu);
`endif
        return r;
    endfunction

    // Ops that run for DIV_CYCLES
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == mdu_div) || (op == mdu_divu);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
// master drives start/mdop/A/B; slave returns busy and the HI/LO registers.
// busy/hi/lo are registered in the slave.
interface mdu_if;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdop, A, B, input busy, hi, lo);
    modport slave  (input start, mdop, A, B, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {HI,LO} result for an mdop given A, B and the current {HI,LO}.
// Latency: zero (purely combinational); the caller registers the result.
// No flow control; codes without an arithmetic meaning return {HI,LO} unchanged.
// MDU_MADD_EN adds the madd/maddu/msub/msubu accumulate forms.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] res
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;

    // Products, special-case detection and per-op result selection
    always_comb begin
        a_sx     = {{32{a[31]}}, a};
        b_sx     = {{32{b[31]}}, b};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, a} * {32'd0, b};
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res      = hilo;
        case (mdop)
            mdu_mult:  res = prod_s;
            mdu_multu: res = prod_u;
            mdu_div: begin
                // Divide-by-zero and INT_MIN/-1 are pinned rather than left to the divider
                if (div_zero)
                    res = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
            end
            mdu_divu: begin
                if (div_zero)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
`ifdef MDU_MADD_EN
            mdu_madd:  res = hilo + prod_s;
            mdu_maddu: res = hilo + prod_u;
            mdu_msub:  res = hilo - prod_s;
            mdu_msubu: res = hilo - prod_u;
`endif
            default:   res = hilo;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: HI/LO registers, IDLE/RUN FSM, cycle counter, pending result.
// Latency: MULT_CYCLES or DIV_CYCLES edges from accept to HI/LO update; mthi/mtlo take one edge.
// busy is high for the whole run; new issues are ignored while busy (upstream stalls on start|busy).
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    mdu_state_t  state;
    logic [3:0]  cnt;
    logic [63:0] pending;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic [63:0] arith_res;

    mdu_arith u_arith (
        .mdop (bus.mdop),
        .a    (bus.A),
        .b    (bus.B),
        .hilo ({hi_q, lo_q}),
        .res  (arith_res)
    );

    // FSM: accept in IDLE, count down in RUN, commit pending result on the last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pending <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mult_op(bus.mdop)) begin
                            pending <= arith_res;
                            cnt     <= 4'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end else if (is_div_op(bus.mdop)) begin
                            pending <= arith_res;
                            cnt     <= 4'(DIV_CYCLES);
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end else if (bus.mdop == mdu_mthi) begin
                            hi_q <= bus.A;
                        end else if (bus.mdop == mdu_mtlo) begin
                            lo_q <= bus.A;
                        end
                    end
                end
                RUN: begin
                    // start is ignored here; hi/lo hold until commit
                    if (cnt == 4'd1) begin
                        hi_q   <= pending[63:32];
                        lo_q   <= pending[31:0];
                        busy_q <= 1'b0;
                        cnt    <= 4'd0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: mult/div latency and results, special divides,
// mthi/mtlo, ignored issue during RUN, async reset mid-operation, optional accumulate ops.
module tb_mdu;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   ncyc;

    mdu_if ifc ();

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one issue at the negedge; return #1 after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.mdop  = op;
        ifc.A     = a;
        ifc.B     = b;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.mdop  = mdu_none;
    endtask

    // Count edges until busy drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (ifc.busy === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        ifc.start = 1'b0;
        ifc.mdop  = mdu_none;
        ifc.A     = 32'd0;
        ifc.B     = 32'd0;
        #12;
        check("rst_busy", {31'd0, ifc.busy}, 32'd0);
        check("rst_hi", ifc.hi, 32'd0);
        check("rst_lo", ifc.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // signed mult: -2 * 3 = -6
        issue(mdu_mult, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_e0", {31'd0, ifc.busy}, 32'd1);
        check("mult_hold_lo", ifc.lo, 32'd0);
        wait_idle(ncyc);
        check("mult_cycles", ncyc, NM);
        check("mult_hi", ifc.hi, 32'hFFFF_FFFF);
        check("mult_lo", ifc.lo, 32'hFFFF_FFFA);

        // back-to-back: issued in the first cycle busy reads 0
        issue(mdu_multu, 32'hFFFF_FFFE, 32'd3);
        check("multu_busy_e0", {31'd0, ifc.busy}, 32'd1);
        wait_idle(ncyc);
        check("multu_cycles", ncyc, NM);
        check("multu_hi", ifc.hi, 32'h0000_0002);
        check("multu_lo", ifc.lo, 32'hFFFF_FFFA);

        // signed div: -7 / 2 -> q=-3, r=-1
        issue(mdu_div, 32'hFFFF_FFF9, 32'd2);
        wait_idle(ncyc);
        check("div_cycles", ncyc, ND);
        check("div_lo", ifc.lo, 32'hFFFF_FFFD);
        check("div_hi", ifc.hi, 32'hFFFF_FFFF);

        issue(mdu_divu, 32'd7, 32'd2);
        wait_idle(ncyc);
        check("divu_lo", ifc.lo, 32'd3);
        check("divu_hi", ifc.hi, 32'd1);

        issue(mdu_divu, 32'h1234, 32'd0);
        wait_idle(ncyc);
        check("divu0_hi", ifc.hi, 32'h1234);
        check("divu0_lo", ifc.lo, 32'hFFFF_FFFF);

        issue(mdu_div, 32'hFFFF_FF00, 32'd0);
        wait_idle(ncyc);
        check("div0_hi", ifc.hi, 32'hFFFF_FF00);
        check("div0_lo", ifc.lo, 32'hFFFF_FFFF);

        issue(mdu_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(ncyc);
        check("divovf_lo", ifc.lo, 32'h8000_0000);
        check("divovf_hi", ifc.hi, 32'd0);

        // mthi during RUN must be ignored: 100 / 7 -> q=14, r=2
        issue(mdu_div, 32'd100, 32'd7);
        issue(mdu_mthi, 32'hAAAA, 32'd0);
        check("run_busy", {31'd0, ifc.busy}, 32'd1);
        check("run_hold_hi", ifc.hi, 32'd0);
        wait_idle(ncyc);
        check("run_cycles", ncyc, ND - 1);
        check("run_hi", ifc.hi, 32'd2);
        check("run_lo", ifc.lo, 32'd14);

        // mtlo in IDLE: visible next edge, no busy
        issue(mdu_mtlo, 32'd5, 32'd0);
        check("mtlo_lo", ifc.lo, 32'd5);
        check("mtlo_hi", ifc.hi, 32'd2);
        check("mtlo_busy", {31'd0, ifc.busy}, 32'd0);

        issue(mdu_mthi, 32'h0BAD_F00D, 32'd0);
        check("mthi_hi", ifc.hi, 32'h0BAD_F00D);
        check("mthi_busy", {31'd0, ifc.busy}, 32'd0);

        // unused code 15: no busy, no change
        issue(4'd15, 32'd9, 32'd9);
        check("op15_busy", {31'd0, ifc.busy}, 32'd0);
        check("op15_lo", ifc.lo, 32'd5);

        // async reset three cycles into a div
        issue(mdu_div, 32'd1000, 32'd3);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, ifc.busy}, 32'd0);
        check("arst_hi", ifc.hi, 32'd0);
        check("arst_lo", ifc.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(mdu_mult, 32'd2, 32'd3);
        wait_idle(ncyc);
        check("post_rst_cycles", ncyc, NM);
        check("post_rst_lo", ifc.lo, 32'd6);
        check("post_rst_hi", ifc.hi, 32'd0);

`ifdef MDU_MADD_EN
        issue(mdu_mthi, 32'd0, 32'd0);
        issue(mdu_mtlo, 32'hFFFF_FFFF, 32'd0);
        issue(mdu_maddu, 32'd1, 32'd1);
        wait_idle(ncyc);
        check("maddu_cycles", ncyc, NM);
        check("maddu_hi", ifc.hi, 32'd1);
        check("maddu_lo", ifc.lo, 32'd0);
        // {1,0} - (-1*1) = {1,1}
        issue(mdu_msub, 32'hFFFF_FFFF, 32'd1);
        wait_idle(ncyc);
        check("msub_hi", ifc.hi, 32'd1);
        check("msub_lo", ifc.lo, 32'd1);
`else
        issue(mdu_maddu, 32'd1, 32'd1);
        check("maddu_off_busy", {31'd0, ifc.busy}, 32'd0);
        check("maddu_off_hi", ifc.hi, 32'd0);
        check("maddu_off_lo", ifc.lo, 32'd6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU. It accepts signed and unsigned mult and div operations and mthi/mtlo writes. Results go to internal HI/LO registers after a fixed latency. `busy` drives the pipeline stall logic, so later HI/LO-dependent instructions wait in D until the operation completes.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd family); legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `start`, input, 1: issue pulse from EX, valid for one cycle per instruction.
- `mdop`, input, 4: operation code, sampled when `start`=1.
- `A`, input, 32: rs operand (forwarded value).
- `B`, input, 32: rt operand (forwarded value).
- `busy`, output, 1: operation in flight.
- `hi`, output, 32: HI register.
- `lo`, output, 32: LO register.

## Operation
- `mdop` codes:
  - 0: none
  - 1: mult, 2: multu, 3: div, 4: divu
  - 5: mthi, 6: mtlo
  - 7: madd, 8: maddu, 9: msub, 10: msubu
  - any other code: treated as none.
- States:
  - IDLE --start & (mult/div family)--> RUN
  - RUN --cnt==1--> IDLE, commit
  - RUN ignores `start`.
- On accept, latch the pending {HI,LO} result and load `cnt` with MULT_CYCLES or DIV_CYCLES.
- mult: {HI,LO} = signed 64-bit A*B. multu: the same product, unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of A.
- divu: unsigned quotient and remainder.
- Division by zero (B==0), both signed and unsigned: HI=A, LO=32'hFFFF_FFFF.
- Signed overflow, 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi and mtlo:
  - Accepted only in IDLE.
  - Write HI or LO at the next edge; no busy.
  - Any of these or other codes presented during RUN are ignored; upstream stall guarantees none arrive.
- Reset at any time, including mid-RUN:
  - Aborts the operation.
  - Forces state=IDLE, cnt=0, hi=0, lo=0, busy=0.

## Timing
- `start` is sampled at edge E0 and the unit enters RUN.
- `busy` is high from E0 for N cycles (N = MULT_CYCLES or DIV_CYCLES).
- At edge E0+N, hi/lo take the result and `busy` falls in the same update.
  - Result is visible and busy is low from E0+N onward.
- mthi/mtlo: hi/lo show the new value one cycle after `start`; `busy` stays 0.
- A back-to-back `start` in the cycle `busy` first reads 0 is accepted.
- hi/lo hold their previous values throughout RUN.
- `busy` and hi/lo are registered outputs; there is no combinational path from inputs to outputs.
- Stall rule for upstream logic: stall any HI/LO instruction in D while `start` | `busy`.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined:
  - madd/maddu: {HI,LO} += the signed/unsigned 64-bit product, mod 2^64.
  - msub/msubu: {HI,LO} -= the signed/unsigned 64-bit product, mod 2^64.
  - All four use MULT_CYCLES latency.
- Undefined: codes 7..10 are treated as none, with no busy and no HI/LO change.

## Structure
- Add these to shared `constants.v`, next to the ALU op defines:
  - `mdu_none`, `mdu_mult`, `mdu_multu`, `mdu_div`, `mdu_divu`, `mdu_mthi`, `mdu_mtlo`, `mdu_madd`, `mdu_maddu`, `mdu_msub`, `mdu_msubu`
- One sub-module, `mdu_arith`:
  - Combinational 64-bit result computation from mdop, A, B and current {HI,LO}, including the divide-by-zero and overflow rules.
  - Top level `mdu` holds the FSM, `cnt`, and the pending-result register.

## Test plan
- mult A=0xFFFFFFFE, B=3 -> busy 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- divu A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xAAAA during RUN -> ignored; mtlo A=5 in IDLE -> lo=5 next cycle, busy stays 0.
- Assert reset 3 cycles into a div -> busy=0, hi=lo=0 immediately. A subsequent mult 2*3 yields LO=6, HI=0.
- With `MDU_MADD_EN` defined: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0.
